// File: rtl/alu_add_arb.sv
// alu_add_arb: shares one 32-bit adder among NUM_REQ requesters.
// Requesters are granted one per cycle; the sum, carry and requester ID are
// returned from a registered output stage that supports backpressure.
//
// Build option: define ALU_ADD_ARB_FIXED_PRIO_EN for fixed-priority
// arbitration (lowest asserted index wins, no rotating pointer). With the
// macro undefined the arbiter is round-robin.
//
// Handshake: a transfer on either side happens on a rising edge where
// valid && ready are both high. The requester side may not make req_valid
// depend on req_ready, and must hold operands stable while req_valid is high.
// The response holds rsp_result/rsp_carry/rsp_id stable while
// rsp_valid && !rsp_ready.
module alu_add_arb #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*32-1:0]   req_data0,
  input  logic [NUM_REQ*32-1:0]   req_data1,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [31:0]             rsp_result,
  output logic                    rsp_carry,
  output logic [ID_W-1:0]         rsp_id
);

  localparam int PW = ID_W + 1;

  logic               accept;
  logic               any_grant;
  logic               transfer;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_id;
  logic [ID_W-1:0]    scan_start;
  logic [PW-1:0]      scan_wide;
  logic [ID_W-1:0]    scan_idx;
  logic [31:0]        op_a;
  logic [31:0]        op_b;
  logic [32:0]        sum;

  // The output register can take a new response when it is empty or draining.
  assign accept = !rsp_valid || rsp_ready;

`ifdef ALU_ADD_ARB_FIXED_PRIO_EN
  // Fixed priority: the scan always begins at requester 0.
  assign scan_start = '0;
`else
  logic [ID_W-1:0] rr_ptr;
  assign scan_start = rr_ptr;
`endif

  // Pick the first valid requester scanning upward from scan_start, wrapping.
  always_comb begin
    grant     = '0;
    grant_id  = '0;
    any_grant = 1'b0;
    scan_wide = '0;
    scan_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_wide = {1'b0, scan_start} + PW'(k);
      if (scan_wide >= PW'(NUM_REQ)) scan_wide = scan_wide - PW'(NUM_REQ);
      scan_idx = scan_wide[ID_W-1:0];
      if (!any_grant && req_valid[scan_idx]) begin
        grant[scan_idx] = 1'b1;
        grant_id        = scan_idx;
        any_grant       = 1'b1;
      end
    end
  end

  // Grants are only exposed when the output stage can accept and not in reset.
  assign req_ready = (rst_n && accept) ? grant : '0;
  assign transfer  = rst_n && accept && any_grant;

  // Route the winner's operands into the single shared adder.
  always_comb begin
    op_a = '0;
    op_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == ID_W'(i)) begin
        op_a = req_data0[32*i +: 32];
        op_b = req_data1[32*i +: 32];
      end
    end
  end

  assign sum = {1'b0, op_a} + {1'b0, op_b};

  // Output stage: load on transfer, clear valid on drain, hold while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
      rsp_id     <= '0;
    end else if (transfer) begin
      rsp_valid  <= 1'b1;
      rsp_result <= sum[31:0];
      rsp_carry  <= sum[32];
      rsp_id     <= grant_id;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid  <= 1'b0;
    end
  end

`ifndef ALU_ADD_ARB_FIXED_PRIO_EN
  // Round-robin pointer moves just past the winner, only when a transfer occurs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (transfer) begin
      if (grant_id == ID_W'(NUM_REQ - 1)) rr_ptr <= '0;
      else                                rr_ptr <= grant_id + ID_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_alu_add_arb.sv
// tb_alu_add_arb: directed tests for alu_add_arb (NUM_REQ=4, ID_W=2).
// Compile with ALU_ADD_ARB_FIXED_PRIO_EN to run the fixed-priority scenario
// in place of the round-robin ones.
module tb_alu_add_arb;

  logic         clk;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_data0;
  logic [127:0] req_data1;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [31:0]  rsp_result;
  logic         rsp_carry;
  logic [1:0]   rsp_id;

  int n_checks;
  int n_errors;

  alu_add_arb #(.NUM_REQ(4), .ID_W(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data0  (req_data0),
    .req_data1  (req_data1),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_carry  (rsp_carry),
    .rsp_id     (rsp_id)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks: inputs change at the falling edge, DUT samples at the rising edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
    req_data0[32*i +: 32] = a;
    req_data1[32*i +: 32] = b;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    n_checks++; if (req_ready !== 4'b0000) begin n_errors++; $display("FAIL reset_ready got %b exp %b", req_ready, 4'b0000); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid got %b exp 0", rsp_valid); end
    n_checks++; if (rsp_result !== 32'h0) begin n_errors++; $display("FAIL reset_result got %h exp 0", rsp_result); end
    n_checks++; if (rsp_carry !== 1'b0) begin n_errors++; $display("FAIL reset_carry got %b exp 0", rsp_carry); end
    n_checks++; if (rsp_id !== 2'd0) begin n_errors++; $display("FAIL reset_id got %0d exp 0", rsp_id); end
    set_ops(0, 32'd5, 32'd7);
    rst_n = 1'b1;
    #1;
    n_checks++; if (req_ready !== 4'b0001) begin n_errors++; $display("FAIL first_grant got %b exp %b", req_ready, 4'b0001); end
    tick();
    n_checks++; if (rsp_valid !== 1'b1) begin n_errors++; $display("FAIL first_rsp_valid got %b exp 1", rsp_valid); end
    n_checks++; if (rsp_id !== 2'd0) begin n_errors++; $display("FAIL first_rsp_id got %0d exp 0", rsp_id); end
    n_checks++; if (rsp_result !== 32'd12) begin n_errors++; $display("FAIL first_rsp_result got %h exp %h", rsp_result, 32'd12); end
    // Reset in the middle of a pending response.
    rst_n = 1'b0;
    #1;
    n_checks++; if (rsp_valid !== 1'b0) begin n_errors++; $display("FAIL midreset_valid got %b exp 0", rsp_valid); end
    n_checks++; if (rsp_result !== 32'h0) begin n_errors++; $display("FAIL midreset_result got %h exp 0", rsp_result); end
    n_checks++; if (rsp_id !== 2'd0) begin n_errors++; $display("FAIL midreset_id got %0d exp 0", rsp_id); end
    n_checks++; if (req_ready !== 4'b0000) begin n_errors++; $display("FAIL midreset_ready got %b exp %b", req_ready, 4'b0000); end
    req_valid = 4'h0;
    tick();
    rst_n = 1'b1;
    tick();
    req_valid = 4'hF;
    #1;
    n_checks++; if (req_ready !== 4'b0001) begin n_errors++; $display("FAIL post_reset_grant got %b exp %b", req_ready, 4'b0001); end
    req_valid = 4'h0;
    #1;
  endtask

  task automatic test_single_wrap();
    set_ops(1, 32'hFFFF_FFFF, 32'h0000_0001);
    req_valid = 4'b0010;
    rsp_ready = 1'b1;
    #1;
    n_checks++; if (req_ready !== 4'b0010) begin n_errors++; $display("FAIL wrap_grant got %b exp %b", req_ready, 4'b0010); end
    tick();
    req_valid = 4'b0000;
    #1;
    n_checks++; if (rsp_valid !== 1'b1) begin n_errors++; $display("FAIL wrap_valid got %b exp 1", rsp_valid); end
    n_checks++; if (rsp_result !== 32'h0) begin n_errors++; $display("FAIL wrap_result got %h exp 0", rsp_result); end
    n_checks++; if (rsp_carry !== 1'b1) begin n_errors++; $display("FAIL wrap_carry got %b exp 1", rsp_carry); end
    n_checks++; if (rsp_id !== 2'd1) begin n_errors++; $display("FAIL wrap_id got %0d exp 1", rsp_id); end
    tick();
    n_checks++; if (rsp_valid !== 1'b0) begin n_errors++; $display("FAIL drain_valid got %b exp 0", rsp_valid); end
    n_checks++; if (rsp_id !== 2'd1) begin n_errors++; $display("FAIL drain_hold_id got %0d exp 1", rsp_id); end
    n_checks++; if (rsp_carry !== 1'b1) begin n_errors++; $display("FAIL drain_hold_carry got %b exp 1", rsp_carry); end
  endtask

  task automatic test_rotation();
    logic [3:0]  exp_gnt [5];
    logic [1:0]  exp_id  [5];
    logic [31:0] exp_res [5];
    exp_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_id  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    exp_res = '{32'h30, 32'h31, 32'h32, 32'h33, 32'h30};
    pulse_reset();
    for (int i = 0; i < 4; i++) set_ops(i, 32'h10, 32'h20 + 32'(i));
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_checks++; if (req_ready !== exp_gnt[k]) begin n_errors++; $display("FAIL rr_grant[%0d] got %b exp %b", k, req_ready, exp_gnt[k]); end
      tick();
      n_checks++; if (rsp_valid !== 1'b1) begin n_errors++; $display("FAIL rr_valid[%0d] got %b exp 1", k, rsp_valid); end
      n_checks++; if (rsp_id !== exp_id[k]) begin n_errors++; $display("FAIL rr_id[%0d] got %0d exp %0d", k, rsp_id, exp_id[k]); end
      n_checks++; if (rsp_result !== exp_res[k]) begin n_errors++; $display("FAIL rr_result[%0d] got %h exp %h", k, rsp_result, exp_res[k]); end
    end
  endtask

  task automatic test_backpressure();
    // Pointer sits at 1; only requester 2 asks.
    set_ops(2, 32'h1234_5600, 32'h0000_0078);
    req_valid = 4'b0100;
    #1;
    n_checks++; if (req_ready !== 4'b0100) begin n_errors++; $display("FAIL bp_grant got %b exp %b", req_ready, 4'b0100); end
    tick();
    set_ops(3, 32'd1, 32'd2);
    rsp_ready = 1'b0;
    req_valid = 4'hF;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++; if (req_ready !== 4'b0000) begin n_errors++; $display("FAIL stall_ready[%0d] got %b exp %b", k, req_ready, 4'b0000); end
      n_checks++; if (rsp_valid !== 1'b1) begin n_errors++; $display("FAIL stall_valid[%0d] got %b exp 1", k, rsp_valid); end
      n_checks++; if (rsp_result !== 32'h1234_5678) begin n_errors++; $display("FAIL stall_result[%0d] got %h exp %h", k, rsp_result, 32'h1234_5678); end
      n_checks++; if (rsp_id !== 2'd2) begin n_errors++; $display("FAIL stall_id[%0d] got %0d exp 2", k, rsp_id); end
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    n_checks++; if (req_ready !== 4'b1000) begin n_errors++; $display("FAIL release_grant got %b exp %b", req_ready, 4'b1000); end
    tick();
    req_valid = 4'h0;
    #1;
    n_checks++; if (rsp_valid !== 1'b1) begin n_errors++; $display("FAIL release_valid got %b exp 1", rsp_valid); end
    n_checks++; if (rsp_result !== 32'd3) begin n_errors++; $display("FAIL release_result got %h exp %h", rsp_result, 32'd3); end
    n_checks++; if (rsp_id !== 2'd3) begin n_errors++; $display("FAIL release_id got %0d exp 3", rsp_id); end
    tick();
    n_checks++; if (rsp_valid !== 1'b0) begin n_errors++; $display("FAIL bp_drain_valid got %b exp 0", rsp_valid); end
  endtask

  task automatic test_sparse();
    // Pointer sits at 0.
    set_ops(3, 32'h100, 32'h200);
    req_valid = 4'b1000;
    #1;
    n_checks++; if (req_ready !== 4'b1000) begin n_errors++; $display("FAIL sparse_grant3 got %b exp %b", req_ready, 4'b1000); end
    tick();
    n_checks++; if (rsp_result !== 32'h300) begin n_errors++; $display("FAIL sparse_result3 got %h exp %h", rsp_result, 32'h300); end
    set_ops(2, 32'hAAAA_AAAA, 32'h5555_5555);
    req_valid = 4'b0100;
    #1;
    n_checks++; if (req_ready !== 4'b0100) begin n_errors++; $display("FAIL sparse_grant2 got %b exp %b", req_ready, 4'b0100); end
    tick();
    n_checks++; if (rsp_id !== 2'd2) begin n_errors++; $display("FAIL sparse_id2 got %0d exp 2", rsp_id); end
    n_checks++; if (rsp_result !== 32'hFFFF_FFFF) begin n_errors++; $display("FAIL sparse_result2 got %h exp %h", rsp_result, 32'hFFFF_FFFF); end
    n_checks++; if (rsp_carry !== 1'b0) begin n_errors++; $display("FAIL sparse_carry2 got %b exp 0", rsp_carry); end
    req_valid = 4'hF;
    #1;
    n_checks++; if (req_ready !== 4'b1000) begin n_errors++; $display("FAIL sparse_ptr3 got %b exp %b", req_ready, 4'b1000); end
    req_valid = 4'h0;
    tick();
    n_checks++; if (rsp_valid !== 1'b0) begin n_errors++; $display("FAIL sparse_drain got %b exp 0", rsp_valid); end
  endtask

  task automatic test_fixed_prio();
    pulse_reset();
    set_ops(1, 32'd1, 32'd1);
    set_ops(3, 32'd2, 32'd2);
    req_valid = 4'b1010;
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_checks++; if (req_ready !== 4'b0010) begin n_errors++; $display("FAIL fp_grant[%0d] got %b exp %b", k, req_ready, 4'b0010); end
      tick();
      n_checks++; if (rsp_id !== 2'd1) begin n_errors++; $display("FAIL fp_id[%0d] got %0d exp 1", k, rsp_id); end
      n_checks++; if (rsp_result !== 32'd2) begin n_errors++; $display("FAIL fp_result[%0d] got %h exp %h", k, rsp_result, 32'd2); end
    end
    req_valid = 4'h0;
    tick();
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    req_data0 = '0;
    req_data1 = '0;
    test_reset();
    test_single_wrap();
`ifdef ALU_ADD_ARB_FIXED_PRIO_EN
    test_fixed_prio();
`else
    test_rotation();
    test_backpressure();
    test_sparse();
`endif
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
